nn_seq: RTL and testbench
=========================

# nn_seq

Inference sequencer for the two-layer MNIST MLP (784→32→10). It sits between the AXI register block and the four weight/bias ROMs plus the pixel buffer, and sequences a full forward pass on `start`. It walks ROM addresses, performs int8×uint8 multiply-accumulate with ReLU/requantisation on the hidden layer, and reports the argmax class on `predicted` with a one-cycle `done` pulse.

## Interface
- `N_IN`, 784: input pixels.
- `N_HID`, 32: hidden neurons.
- `N_OUT`, 10: output classes.
- `SHIFT`, 8: right-shift applied to the ReLU'd hidden accumulator before saturation.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin inference. Sampled only in IDLE.
- `busy`  out  1  high from the cycle after start is accepted until `done`.
- `done`  out  1  single-cycle pulse; `predicted`/`max_score` valid from this cycle.
- `predicted`  out  4  argmax class.
- `max_score`  out  32  winning layer-2 accumulator (signed).
- `x_en`/`x_addr`/`x_dout`  out/out/in  1/10/8  pixel buffer read, 1-cycle latency, unsigned.
- `b1_en`/`b1_addr`/`b1_dout`  out/out/in  1/5/32  signed.
- `w1_en`/`w1_addr`/`w1_dout`  out/out/in  1/15/8  signed, row-major: addr = j*N_IN+i.
- `w2_en`/`w2_addr`/`w2_dout`  out/out/in  1/9/8  signed, addr = k*N_HID+j.
- `b2_en`/`b2_addr`/`b2_dout`  out/out/in  1/4/32  signed.

## Operation
- States: IDLE → L1 → L1_STORE → (next j or L2) → L2 → L2_CMP → (next k or FINISH) → IDLE.
- L1, neuron j:
  - Issue cycles i=0..N_IN-1 drive `x_addr=i` and `w1_addr` (a running counter, no multiplier); `b1_addr=j` is driven on i=0.
  - Data cycles lag by one. On the first data cycle, acc <= b1 + x*w. On subsequent data cycles, acc += x*w.
  - The last data cycle overlaps the drain cycle.
- L1_STORE: h[j] = (acc<0) ? 0 : min(acc>>>SHIFT, 255), stored to an internal 32×8 register file.
- L2, output k: same pattern with h[j] (registered one cycle to align with w2 latency), `w2_addr` running counter, `b2_addr=k`.
- L2_CMP: if k==0 or acc > best, set best=acc and best_idx=k. Strictly greater means ties keep the lowest index.
- FINISH: `predicted`<=best_idx, `max_score`<=best, `done`=1, `busy`=0, return to IDLE.
- Arithmetic: product is 17-bit signed (uint8 zero-extended × int8). Accumulator is 32-bit signed, wraps on overflow with no saturation. Only the hidden store saturates.
- Enables are high only on issue cycles. All ROM addresses are 0 in IDLE.
- `start` while busy: ignored. `start` held high: one inference per IDLE visit.

## Timing
- Reset values: `done`=0, `busy`=0, `predicted`=0, `max_score`=0, all enables 0, all addresses 0, state IDLE. The h file is not reset.
- Per hidden neuron: N_IN+2 cycles (784 issue, 1 drain, 1 store).
- Per output: N_HID+2 cycles.
- Latency, start cycle to `done` cycle: N_HID*(N_IN+2) + N_OUT*(N_HID+2) + 2 = 25494 cycles at defaults.
- `predicted`/`max_score` hold until the next `done` or reset.
- `rst` low mid-inference: state returns to IDLE next edge and outputs take reset values. No partial `done` is emitted.
- Counter wrap: `w1_addr` ends at N_HID*N_IN-1 = 25087 and `w2_addr` at 319. Both are cleared on entry to their layer, never wrapped mid-layer.

## Structure
- Package `nn_pkg`: N_IN/N_HID/N_OUT constants, address widths (clog2-derived), state enum, accumulator/product widths.
- Sub-module `nn_mac`: signed MAC with `load` (acc<=bias+prod), `acc_en`, and `acc` output. It is shared by both layers, with the operand mux in `nn_seq`.
- The h register file and argmax logic live in `nn_seq`.

## Test plan
- All weights 0, b1=0, b2[k]=k*10 → `predicted`=9, `max_score`=90, `done` exactly 25494 cycles after `start`.
- Ties: weights 0, b2 all =7 → `predicted`=0, `max_score`=7.
- ReLU/saturation:
  - Setup: pixels all 255, w1 row 0 all 1, b1[0]=0, w2[k*32+0]=1 for k=4 only, b2=0.
  - Hidden: h[0]=min((784*255)>>8, 255)=255.
  - Result: `predicted`=4, `max_score`=255.
- Negative hidden: same as above but w1 row 0 all -1 → h[0]=0. Result: all scores 0, `predicted`=0.
- Address trace: monitor `w1_addr` strictly incrementing 0..25087 with `w1_en` gaps of 2 cycles per neuron; `x_addr` cycles 0..783 ×32; `b1_addr` = j on each neuron's first issue cycle.
- `start` pulsed mid-inference → ignored, single `done`. `rst` low at cycle 10000 → `busy`/`done`/`predicted`=0. A new `start` then completes normally in 25494 cycles.

Source files
------------

// File: rtl/nn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nn_pkg : shared constants, widths and state type for nn_seq         |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package nn_pkg;

   localparam int N_IN   = 784;
   localparam int N_HID  = 32;
   localparam int N_OUT  = 10;
   localparam int SHIFT  = 8;

   localparam int X_AW   = $clog2(N_IN);
   localparam int B1_AW  = $clog2(N_HID);
   localparam int W1_AW  = $clog2(N_HID * N_IN);
   localparam int W2_AW  = $clog2(N_OUT * N_HID);
   localparam int B2_AW  = $clog2(N_OUT);
   localparam int IDX_W  = $clog2(N_IN + 1);

   localparam int PROD_W = 17;
   localparam int ACC_W  = 32;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_L1       = 3'd1,
      S_L1_STORE = 3'd2,
      S_L2       = 3'd3,
      S_L2_CMP   = 3'd4,
      S_FINISH   = 3'd5
   } state_t;

   // ReLU, requantise by SHIFT, then clamp to the uint8 hidden range.
   function automatic logic [7:0] relu_sat(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] sh;
      sh = acc >>> SHIFT;
      if (acc < 0)
         return 8'd0;
      else if (sh > 255)
         return 8'd255;
      else
         return sh[7:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/nn_mac.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nn_mac : uint8 x int8 multiply-accumulate, 32-bit wrapping acc      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module nn_mac
   import nn_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic                    acc_en,
   input  logic [7:0]              a,
   input  logic signed [7:0]       w,
   input  logic signed [ACC_W-1:0] bias,
   output logic signed [ACC_W-1:0] acc
);

   logic signed [PROD_W-1:0] a_ext;
   logic signed [PROD_W-1:0] w_ext;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc_d;
   logic signed [ACC_W-1:0]  acc_q;

   always_comb begin
      a_ext    = {{(PROD_W-8){1'b0}}, a};
      w_ext    = {{(PROD_W-8){w[7]}}, w};
      prod     = a_ext * w_ext;
      prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      acc_d    = acc_q;
      if (load)
         acc_d = bias + prod_ext;
      else if (acc_en)
         acc_d = acc_q + prod_ext;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         acc_q <= '0;
      else
         acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule
`default_nettype wire

// File: rtl/nn_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nn_seq : forward-pass sequencer for the 784-32-10 MLP, argmax out   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module nn_seq
   import nn_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic [B2_AW-1:0]        predicted,
   output logic signed [ACC_W-1:0] max_score,
   output logic                    x_en,
   output logic [X_AW-1:0]         x_addr,
   input  logic [7:0]              x_dout,
   output logic                    b1_en,
   output logic [B1_AW-1:0]        b1_addr,
   input  logic signed [ACC_W-1:0] b1_dout,
   output logic                    w1_en,
   output logic [W1_AW-1:0]        w1_addr,
   input  logic signed [7:0]       w1_dout,
   output logic                    w2_en,
   output logic [W2_AW-1:0]        w2_addr,
   input  logic signed [7:0]       w2_dout,
   output logic                    b2_en,
   output logic [B2_AW-1:0]        b2_addr,
   input  logic signed [ACC_W-1:0] b2_dout
);

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [B1_AW-1:0]        nrn_q, nrn_d;
   logic signed [ACC_W-1:0] best_q, best_d;
   logic [B2_AW-1:0]        best_idx_q, best_idx_d;
   logic [B2_AW-1:0]        predicted_q, predicted_d;
   logic signed [ACC_W-1:0] max_score_q, max_score_d;
   logic                    done_q, done_d;
   logic                    busy_q, busy_d;
   logic                    x_en_q, x_en_d, w1_en_q, w1_en_d, b1_en_q, b1_en_d;
   logic                    w2_en_q, w2_en_d, b2_en_q, b2_en_d;
   logic [X_AW-1:0]         x_addr_q, x_addr_d;
   logic [W1_AW-1:0]        w1_addr_q, w1_addr_d;
   logic [B1_AW-1:0]        b1_addr_q, b1_addr_d;
   logic [W2_AW-1:0]        w2_addr_q, w2_addr_d;
   logic [B2_AW-1:0]        b2_addr_q, b2_addr_d;
   logic                    ld_q, ld_d, mac_en_q, mac_en_d, l2_dat_q, l2_dat_d;
   logic [7:0]              h_rd_q, h_rd_d;
   logic                    l1_iss_d, l2_iss_d;
   logic [7:0]              h_q [N_HID];
   logic signed [ACC_W-1:0] acc;
   logic [7:0]              mac_a;
   logic signed [7:0]       mac_w;
   logic signed [ACC_W-1:0] mac_bias;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      nrn_d       = nrn_q;
      best_d      = best_q;
      best_idx_d  = best_idx_q;
      predicted_d = predicted_q;
      max_score_d = max_score_q;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_L1;
               idx_d   = '0;
               nrn_d   = '0;
            end
         end
         S_L1: begin
            // idx == N_IN is the drain cycle: last product lands, nothing issued
            if (idx_q == IDX_W'(N_IN))
               state_d = S_L1_STORE;
            else
               idx_d = idx_q + IDX_W'(1);
         end
         S_L1_STORE: begin
            idx_d = '0;
            if (nrn_q == B1_AW'(N_HID - 1)) begin
               state_d = S_L2;
               nrn_d   = '0;
            end else begin
               state_d = S_L1;
               nrn_d   = nrn_q + B1_AW'(1);
            end
         end
         S_L2: begin
            if (idx_q == IDX_W'(N_HID))
               state_d = S_L2_CMP;
            else
               idx_d = idx_q + IDX_W'(1);
         end
         S_L2_CMP: begin
            if (nrn_q == '0 || acc > best_q) begin
               best_d     = acc;
               best_idx_d = nrn_q[B2_AW-1:0];
            end
            idx_d = '0;
            if (nrn_q == B1_AW'(N_OUT - 1)) begin
               state_d = S_FINISH;
            end else begin
               state_d = S_L2;
               nrn_d   = nrn_q + B1_AW'(1);
            end
         end
         S_FINISH: begin
            predicted_d = best_idx_q;
            max_score_d = best_q;
            done_d      = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // ROM-side outputs are registered, so they are derived from the next state.
      l1_iss_d  = (state_d == S_L1) && (idx_d < IDX_W'(N_IN));
      l2_iss_d  = (state_d == S_L2) && (idx_d < IDX_W'(N_HID));
      busy_d    = (state_d != S_IDLE);
      x_en_d    = l1_iss_d;
      w1_en_d   = l1_iss_d;
      b1_en_d   = l1_iss_d && (idx_d == '0);
      w2_en_d   = l2_iss_d;
      b2_en_d   = l2_iss_d && (idx_d == '0);
      x_addr_d  = l1_iss_d ? idx_d[X_AW-1:0] : '0;
      b1_addr_d = b1_en_d ? nrn_d : '0;
      b2_addr_d = b2_en_d ? nrn_d[B2_AW-1:0] : '0;

      w1_addr_d = w1_addr_q;
      if (state_d == S_IDLE)
         w1_addr_d = '0;
      else if (l1_iss_d)
         w1_addr_d = (state_q == S_IDLE) ? '0 : w1_addr_q + W1_AW'(1);

      w2_addr_d = w2_addr_q;
      if (state_d == S_IDLE)
         w2_addr_d = '0;
      else if (l2_iss_d)
         w2_addr_d = (state_q == S_L1_STORE) ? '0 : w2_addr_q + W2_AW'(1);

      // Data-cycle controls trail the issue cycle by the one-cycle ROM latency.
      ld_d     = b1_en_q | b2_en_q;
      mac_en_d = (x_en_q | w2_en_q) & ~(b1_en_q | b2_en_q);
      l2_dat_d = w2_en_q;
      h_rd_d   = h_q[idx_q[B1_AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         nrn_q       <= '0;
         best_q      <= '0;
         best_idx_q  <= '0;
         predicted_q <= '0;
         max_score_q <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         x_en_q      <= 1'b0;
         w1_en_q     <= 1'b0;
         b1_en_q     <= 1'b0;
         w2_en_q     <= 1'b0;
         b2_en_q     <= 1'b0;
         x_addr_q    <= '0;
         w1_addr_q   <= '0;
         b1_addr_q   <= '0;
         w2_addr_q   <= '0;
         b2_addr_q   <= '0;
         ld_q        <= 1'b0;
         mac_en_q    <= 1'b0;
         l2_dat_q    <= 1'b0;
         h_rd_q      <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         nrn_q       <= nrn_d;
         best_q      <= best_d;
         best_idx_q  <= best_idx_d;
         predicted_q <= predicted_d;
         max_score_q <= max_score_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         x_en_q      <= x_en_d;
         w1_en_q     <= w1_en_d;
         b1_en_q     <= b1_en_d;
         w2_en_q     <= w2_en_d;
         b2_en_q     <= b2_en_d;
         x_addr_q    <= x_addr_d;
         w1_addr_q   <= w1_addr_d;
         b1_addr_q   <= b1_addr_d;
         w2_addr_q   <= w2_addr_d;
         b2_addr_q   <= b2_addr_d;
         ld_q        <= ld_d;
         mac_en_q    <= mac_en_d;
         l2_dat_q    <= l2_dat_d;
         h_rd_q      <= h_rd_d;
      end
   end

   // Hidden activations carry no reset; every entry is rewritten before layer 2 reads it.
   always_ff @(posedge clk) begin
      if (rst && state_q == S_L1_STORE)
         h_q[nrn_q] <= relu_sat(acc);
   end

   always_comb begin
      mac_a    = l2_dat_q ? h_rd_q  : x_dout;
      mac_w    = l2_dat_q ? w2_dout : w1_dout;
      mac_bias = l2_dat_q ? b2_dout : b1_dout;
   end

   nn_mac u_mac (
      .clk    (clk),
      .rst    (rst),
      .load   (ld_q),
      .acc_en (mac_en_q),
      .a      (mac_a),
      .w      (mac_w),
      .bias   (mac_bias),
      .acc    (acc)
   );

   assign busy      = busy_q;
   assign done      = done_q;
   assign predicted = predicted_q;
   assign max_score = max_score_q;
   assign x_en      = x_en_q;
   assign x_addr    = x_addr_q;
   assign b1_en     = b1_en_q;
   assign b1_addr   = b1_addr_q;
   assign w1_en     = w1_en_q;
   assign w1_addr   = w1_addr_q;
   assign w2_en     = w2_en_q;
   assign w2_addr   = w2_addr_q;
   assign b2_en     = b2_en_q;
   assign b2_addr   = b2_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_nn_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_nn_seq : self-checking bench for nn_seq with ROM models          |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_nn_seq;
   import nn_pkg::*;

   localparam int LAT = N_HID * (N_IN + 2) + N_OUT * (N_HID + 2) + 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              busy, done;
   logic [3:0]        predicted;
   logic signed [31:0] max_score;
   logic              x_en, b1_en, w1_en, w2_en, b2_en;
   logic [9:0]        x_addr;
   logic [4:0]        b1_addr;
   logic [14:0]       w1_addr;
   logic [8:0]        w2_addr;
   logic [3:0]        b2_addr;
   logic [7:0]        x_dout;
   logic signed [31:0] b1_dout, b2_dout;
   logic signed [7:0] w1_dout, w2_dout;

   logic [7:0]         x_mem  [N_IN];
   logic signed [7:0]  w1_mem [N_HID*N_IN];
   logic signed [31:0] b1_mem [N_HID];
   logic signed [7:0]  w2_mem [N_OUT*N_HID];
   logic signed [31:0] b2_mem [N_OUT];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (x_en)  x_dout  <= x_mem[x_addr];
      if (w1_en) w1_dout <= w1_mem[w1_addr];
      if (b1_en) b1_dout <= b1_mem[b1_addr];
      if (w2_en) w2_dout <= w2_mem[w2_addr];
      if (b2_en) b2_dout <= b2_mem[b2_addr];
   end

   nn_seq dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .predicted(predicted), .max_score(max_score),
      .x_en(x_en), .x_addr(x_addr), .x_dout(x_dout),
      .b1_en(b1_en), .b1_addr(b1_addr), .b1_dout(b1_dout),
      .w1_en(w1_en), .w1_addr(w1_addr), .w1_dout(w1_dout),
      .w2_en(w2_en), .w2_addr(w2_addr), .w2_dout(w2_dout),
      .b2_en(b2_en), .b2_addr(b2_addr), .b2_dout(b2_dout)
   );

   // Straight forward pass over the memory contents with plain integer arithmetic.
   function automatic void ref_model(output int pred, output int score);
      int h [N_HID];
      int acc;
      pred = 0;
      score = 0;
      for (int j = 0; j < N_HID; j++) begin
         acc = int'(b1_mem[j]);
         for (int i = 0; i < N_IN; i++)
            acc += int'(x_mem[i]) * int'(w1_mem[j*N_IN + i]);
         if (acc < 0)                  h[j] = 0;
         else if ((acc >>> SHIFT) > 255) h[j] = 255;
         else                          h[j] = acc >>> SHIFT;
      end
      for (int k = 0; k < N_OUT; k++) begin
         acc = int'(b2_mem[k]);
         for (int j = 0; j < N_HID; j++)
            acc += h[j] * int'(w2_mem[k*N_HID + j]);
         if (k == 0 || acc > score) begin
            score = acc;
            pred  = k;
         end
      end
   endfunction

   task automatic load_random();
      for (int i = 0; i < N_IN; i++)        x_mem[i]  = 8'($urandom_range(0, 255));
      for (int i = 0; i < N_HID*N_IN; i++)  w1_mem[i] = 8'(int'($urandom_range(0, 4)) - 2);
      for (int j = 0; j < N_HID; j++)       b1_mem[j] = int'($urandom_range(0, 8000)) - 4000;
      for (int i = 0; i < N_OUT*N_HID; i++) w2_mem[i] = 8'($urandom);
      for (int k = 0; k < N_OUT; k++)       b2_mem[k] = int'($urandom_range(0, 4000)) - 2000;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (predicted !== 4'd0) begin errors++; $display("FAIL reset_predicted: got %0d want 0", predicted); end
      checks++; if (max_score !== 32'sd0) begin errors++; $display("FAIL reset_max_score: got %0d want 0", max_score); end
      checks++; if ({x_en, w1_en, b1_en, w2_en, b2_en} !== 5'b0) begin
         errors++; $display("FAIL reset_enables: got %b want 00000", {x_en, w1_en, b1_en, w2_en, b2_en}); end
      checks++; if ({x_addr, w1_addr, b1_addr, w2_addr, b2_addr} !== 43'd0) begin
         errors++; $display("FAIL reset_addrs: got %h want 0", {x_addr, w1_addr, b1_addr, w2_addr, b2_addr}); end
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   // Random data plus address trace, mid-run start pulse and done/latency checks.
   task automatic test_random();
      int exp_pred, exp_score, t0, rel, lat, n_done;
      int w1_cnt, w2_cnt, tr1_err, tr2_err, runs1, bad_gap, gap, idle_err;
      logic [3:0] got_pred;
      logic signed [31:0] got_score;
      logic busy_done, busy_first, prev_w1;
      load_random();
      ref_model(exp_pred, exp_score);
      lat = -1; n_done = 0; w1_cnt = 0; w2_cnt = 0; tr1_err = 0; tr2_err = 0;
      runs1 = 0; bad_gap = 0; gap = 0; idle_err = 0; prev_w1 = 1'b0;
      got_pred = 'x; got_score = 'x; busy_done = 1'bx; busy_first = 1'bx;
      @(posedge clk); #1 start = 1'b1; t0 = cyc;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 0; c < LAT + 40; c++) begin
         @(negedge clk);
         rel = cyc - t0;
         if (rel == 1) busy_first = busy;
         if (rel == 6000) start = 1'b1;
         if (rel == 6003) start = 1'b0;
         if (done === 1'b1) begin
            n_done++;
            if (lat < 0) begin lat = rel; got_pred = predicted; got_score = max_score; busy_done = busy; end
         end
         if (w1_en === 1'b1) begin
            if (w1_addr != w1_cnt || x_en !== 1'b1 || x_addr != w1_cnt % N_IN) tr1_err++;
            if (b1_en !== (w1_cnt % N_IN == 0)) tr1_err++;
            if (b1_en === 1'b1 && b1_addr != w1_cnt / N_IN) tr1_err++;
            if (!prev_w1) begin runs1++; if (runs1 > 1 && gap != 2) bad_gap++; end
            w1_cnt++;
            gap = 0;
         end else begin
            if (x_en !== 1'b0 || b1_en !== 1'b0) tr1_err++;
            gap++;
         end
         prev_w1 = w1_en;
         if (w2_en === 1'b1) begin
            if (w2_addr != w2_cnt || b2_en !== (w2_cnt % N_HID == 0)) tr2_err++;
            if (b2_en === 1'b1 && b2_addr != w2_cnt / N_HID) tr2_err++;
            w2_cnt++;
         end else if (b2_en !== 1'b0) tr2_err++;
         if (lat >= 0 && rel == lat + 1 &&
             ({x_en, w1_en, b1_en, w2_en, b2_en} !== 5'b0 ||
              {x_addr, w1_addr, b1_addr, w2_addr, b2_addr} !== 43'd0 || busy !== 1'b0)) idle_err++;
      end
      checks++; if (busy_first !== 1'b1) begin errors++; $display("FAIL rnd_busy_after_start: got %b want 1", busy_first); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL rnd_latency: got %0d want %0d", lat, LAT); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL rnd_done_count: got %0d want 1", n_done); end
      checks++; if (busy_done !== 1'b0) begin errors++; $display("FAIL rnd_busy_at_done: got %b want 0", busy_done); end
      checks++; if (got_pred !== 4'(exp_pred)) begin errors++; $display("FAIL rnd_predicted: got %0d want %0d", got_pred, exp_pred); end
      checks++; if (got_score !== exp_score) begin errors++; $display("FAIL rnd_max_score: got %0d want %0d", got_score, exp_score); end
      checks++; if (predicted !== 4'(exp_pred)) begin errors++; $display("FAIL rnd_predicted_hold: got %0d want %0d", predicted, exp_pred); end
      checks++; if (w1_cnt != N_HID*N_IN || tr1_err != 0) begin
         errors++; $display("FAIL l1_trace: issues %0d want %0d, bad cycles %0d want 0", w1_cnt, N_HID*N_IN, tr1_err); end
      checks++; if (runs1 != N_HID || bad_gap != 0) begin
         errors++; $display("FAIL l1_gaps: runs %0d want %0d, bad gaps %0d want 0", runs1, N_HID, bad_gap); end
      checks++; if (w2_cnt != N_OUT*N_HID || tr2_err != 0) begin
         errors++; $display("FAIL l2_trace: issues %0d want %0d, bad cycles %0d want 0", w2_cnt, N_OUT*N_HID, tr2_err); end
      checks++; if (idle_err != 0) begin errors++; $display("FAIL idle_after_done: got %0d bad want 0", idle_err); end
   endtask

   task automatic test_reset_mid();
      int t0, rel, n_done, late;
      n_done = 0; late = 0;
      @(posedge clk); #1 start = 1'b1; t0 = cyc;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 0; c < 10010; c++) begin
         @(negedge clk);
         rel = cyc - t0;
         if (done === 1'b1) n_done++;
         if (rel == 10000) rst = 1'b0;
         if (rel == 10001) break;
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0 || n_done != 0) begin
         errors++; $display("FAIL rstmid_done: got %b (pulses %0d) want 0", done, n_done); end
      checks++; if (predicted !== 4'd0 || max_score !== 32'sd0) begin
         errors++; $display("FAIL rstmid_result: got %0d/%0d want 0/0", predicted, max_score); end
      checks++; if ({x_en, w1_en, b1_en, w2_en, b2_en} !== 5'b0 || {x_addr, w1_addr, b1_addr, w2_addr, b2_addr} !== 43'd0) begin
         errors++; $display("FAIL rstmid_rom_ports: got en %b addr %h want 0", {x_en, w1_en, b1_en, w2_en, b2_en},
                            {x_addr, w1_addr, b1_addr, w2_addr, b2_addr}); end
      rst = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) late++;
      end
      checks++; if (late != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", late); end
   endtask

   // Saturating and negative hidden units feeding tied outputs; start held high throughout.
   task automatic test_directed();
      int t0, rel, lat;
      logic [3:0] got_pred;
      logic signed [31:0] got_score;
      logic done_next, busy_next;
      for (int i = 0; i < N_IN; i++) x_mem[i] = 8'd255;
      for (int i = 0; i < N_HID*N_IN; i++)
         w1_mem[i] = (i < N_IN) ? 8'sd1 : (i < 2*N_IN) ? -8'sd1 : 8'sd0;
      for (int j = 0; j < N_HID; j++) b1_mem[j] = 0;
      for (int i = 0; i < N_OUT*N_HID; i++) w2_mem[i] = 8'sd0;
      w2_mem[3*N_HID + 0] = 8'sd1;
      w2_mem[6*N_HID + 0] = 8'sd1;
      w2_mem[5*N_HID + 1] = 8'sd2;
      for (int k = 0; k < N_OUT; k++) b2_mem[k] = (k == 3 || k == 5 || k == 6) ? 0 : 100;
      lat = -1; got_pred = 'x; got_score = 'x; done_next = 1'bx; busy_next = 1'bx;
      @(posedge clk); #1 start = 1'b1; t0 = cyc;
      for (int c = 0; c < LAT + 40; c++) begin
         @(negedge clk);
         rel = cyc - t0;
         if (done === 1'b1 && lat < 0) begin lat = rel; got_pred = predicted; got_score = max_score; end
         if (lat >= 0 && rel == lat + 1) begin done_next = done; busy_next = busy; break; end
      end
      checks++; if (lat != LAT) begin errors++; $display("FAIL dir_latency: got %0d want %0d", lat, LAT); end
      checks++; if (got_pred !== 4'd3) begin errors++; $display("FAIL dir_predicted: got %0d want 3", got_pred); end
      checks++; if (got_score !== 32'sd255) begin errors++; $display("FAIL dir_max_score: got %0d want 255", got_score); end
      checks++; if (done_next !== 1'b0) begin errors++; $display("FAIL dir_done_pulse: got %b want 0", done_next); end
      checks++; if (busy_next !== 1'b1) begin errors++; $display("FAIL dir_start_held_restart: got %b want 1", busy_next); end
      start = 1'b0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_random();
      test_reset_mid();
      test_directed();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
